// File: rtl/bits_pkg.sv
// Shared widths and FSM encoding for the bit packer / bit extractor pair.
package bits_pkg;
  localparam int unsigned WORDW = 32;
  localparam int unsigned CODEW = 15;
  localparam int unsigned LENW  = 4;
  localparam int unsigned CNTW  = 6;
  localparam int unsigned ACCW  = WORDW + CODEW;

  typedef enum logic {
    RUN    = 1'b0,
    FLUSH2 = 1'b1
  } state_t;
endpackage

// File: rtl/pack_align.sv
// Masks a code to its length and shifts it to its left-aligned slot in the accumulator.
module pack_align
  import bits_pkg::*;
(
  input  logic [CODEW-1:0] i_code,
  input  logic [LENW-1:0]  i_len,
  input  logic [CNTW-1:0]  i_fill,
  output logic [ACCW-1:0]  o_aligned
);
  logic [CODEW-1:0] w_mask;
  logic [CODEW-1:0] w_code;
  logic [CNTW-1:0]  w_shift;

  always_comb begin
    w_mask    = ~({CODEW{1'b1}} << i_len);
    w_code    = i_code & w_mask;
    // LSB of the code lands at bit ACCW-fill-len; never negative since fill<=31, len<=15
    w_shift   = CNTW'(ACCW) - i_fill - CNTW'(i_len);
    o_aligned = {{(ACCW-CODEW){1'b0}}, w_code} << w_shift;
  end
endmodule

// File: rtl/bit_packer.sv
// Packs variable-length MSB-first codes into 32-bit words, with zero-padded flush.
module bit_packer
  import bits_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             pushin,
  input  logic [LENW-1:0]  lenin,
  input  logic [CODEW-1:0] datain,
  input  logic             flushin,
  output logic             readyout,
  output logic             pushout,
  output logic [WORDW-1:0] dataout,
  output logic [CNTW-1:0]  validout
);
  state_t           r_state, w_state_nx;
  logic [ACCW-1:0]  r_acc, w_acc_nx, w_acc_sum, w_aligned;
  logic [CNTW-1:0]  r_fill, w_fill_nx, w_fill_sum;
  logic             r_pushout, w_pushout_nx;
  logic [WORDW-1:0] r_dataout, w_dataout_nx;
  logic [CNTW-1:0]  r_validout, w_validout_nx;
  logic             w_push, w_flush;

  pack_align u_align (
    .i_code    (datain),
    .i_len     (lenin),
    .i_fill    (r_fill),
    .o_aligned (w_aligned)
  );

  always_comb begin
    w_push     = pushin  && (r_state == RUN);
    w_flush    = flushin && (r_state == RUN);
    w_acc_sum  = w_push ? (r_acc | w_aligned) : r_acc;
    w_fill_sum = w_push ? (r_fill + CNTW'(lenin)) : r_fill;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_acc_nx      = r_acc;
    w_fill_nx     = r_fill;
    w_pushout_nx  = 1'b0;
    w_dataout_nx  = r_dataout;
    w_validout_nx = r_validout;
    case (r_state)
      RUN: begin
        w_acc_nx  = w_acc_sum;
        w_fill_nx = w_fill_sum;
        if (w_fill_sum >= CNTW'(WORDW)) begin
          w_pushout_nx  = 1'b1;
          w_dataout_nx  = w_acc_sum[ACCW-1 -: WORDW];
          w_validout_nx = CNTW'(WORDW);
          w_acc_nx      = w_acc_sum << WORDW;
          w_fill_nx     = w_fill_sum - CNTW'(WORDW);
          // remainder of a flush that overflowed a word goes out next cycle
          if (w_flush) w_state_nx = FLUSH2;
        end else if (w_flush && (w_fill_sum != '0)) begin
          w_pushout_nx  = 1'b1;
          w_dataout_nx  = w_acc_sum[ACCW-1 -: WORDW];
          w_validout_nx = w_fill_sum;
          w_acc_nx      = '0;
          w_fill_nx     = '0;
        end
      end
      FLUSH2: begin
        w_state_nx = RUN;
        if (r_fill != '0) begin
          w_pushout_nx  = 1'b1;
          w_dataout_nx  = r_acc[ACCW-1 -: WORDW];
          w_validout_nx = r_fill;
          w_acc_nx      = '0;
          w_fill_nx     = '0;
        end
      end
      default: w_state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RUN;
      r_acc      <= '0;
      r_fill     <= '0;
      r_pushout  <= 1'b0;
      r_dataout  <= '0;
      r_validout <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_acc      <= w_acc_nx;
      r_fill     <= w_fill_nx;
      r_pushout  <= w_pushout_nx;
      r_dataout  <= w_dataout_nx;
      r_validout <= w_validout_nx;
    end
  end

  assign readyout = (r_state == RUN);
  assign pushout  = r_pushout;
  assign dataout  = r_dataout;
  assign validout = r_validout;
endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: bit-queue reference model feeding a word scoreboard.
module tb_bit_packer;
  import bits_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             pushin, flushin;
  logic [LENW-1:0]  lenin;
  logic [CODEW-1:0] datain;
  logic             readyout, pushout;
  logic [WORDW-1:0] dataout;
  logic [CNTW-1:0]  validout;

  bit_packer dut (
    .clock    (clock),
    .reset    (reset),
    .pushin   (pushin),
    .lenin    (lenin),
    .datain   (datain),
    .flushin  (flushin),
    .readyout (readyout),
    .pushout  (pushout),
    .dataout  (dataout),
    .validout (validout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    int unsigned n;
  } exp_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t        exp_q[$];
  bit          mbits[$];
  bit          m_ready = 1'b1;
  longint unsigned exp_bits = 0;
  longint unsigned obs_bits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drain n model bits MSB-first into one expected word, zero-padded.
  function automatic void emit(input int unsigned n);
    exp_t e;
    e.word = '0;
    e.n    = n;
    for (int unsigned i = 0; i < n; i++) e.word[31-i] = mbits.pop_front();
    exp_bits += n;
    exp_q.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (!reset && pushout === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pushout: got dataout %0h validout %0d expected no word at %0t",
                 dataout, validout, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dataout", dataout, e.word);
        check("validout", validout, e.n);
        obs_bits += validout;
      end
    end
  end

  task automatic op(input bit p, input int unsigned len, input logic [CODEW-1:0] d, input bit f);
    pushin  = p;
    lenin   = LENW'(len);
    datain  = d;
    flushin = f;
    check("readyout", readyout, m_ready);
    if (!m_ready) begin
      m_ready = 1'b1;
    end else begin
      if (p) for (int i = int'(len); i > 0; i--) mbits.push_back(d[i-1]);
      if (mbits.size() >= 32) begin
        emit(32);
        if (f) begin
          m_ready = 1'b0;
          if (mbits.size() > 0) emit(mbits.size());
        end
      end else if (f && mbits.size() > 0) begin
        emit(mbits.size());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) op(1'b0, 0, '0, 1'b0);
  endtask

  task automatic do_reset(input int unsigned n);
    reset   = 1'b1;
    pushin  = 1'b0;
    flushin = 1'b0;
    lenin   = '0;
    datain  = '0;
    repeat (n) @(posedge clock);
    #1;
    reset   = 1'b0;
    mbits.delete();
    exp_q.delete();
    m_ready = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    pushin  = 1'b0;
    flushin = 1'b0;
    lenin   = '0;
    datain  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_pushout", pushout, 1'b0);
    check("rst_readyout", readyout, 1'b1);
    check("rst_dataout", dataout, '0);
    check("rst_validout", validout, '0);
    reset = 1'b0;

    // reset mid-fill discards pending bits
    op(1'b1, 8, 15'h00AB, 1'b0);
    op(1'b1, 5, 15'h001F, 1'b0);
    do_reset(3);
    op(1'b0, 0, '0, 1'b1);
    check("rst_flush_nopush", pushout, 1'b0);
    idle(2);

    for (int i = 0; i < 4; i++) op(1'b1, 8, 15'h00AB, 1'b0);
    idle(2);

    op(1'b1, 15, 15'h7FFF, 1'b0);
    op(1'b1, 15, 15'h0000, 1'b0);
    op(1'b1, 2,  15'h0003, 1'b0);
    op(1'b0, 0, '0, 1'b1);
    check("empty_flush_nopush", pushout, 1'b0);
    idle(1);

    op(1'b1, 4, 15'h7FFF, 1'b0);
    op(1'b0, 0, '0, 1'b1);
    idle(2);

    // overflowing push+flush, then a push dropped while in FLUSH2
    op(1'b1, 15, 15'h7FFF, 1'b0);
    op(1'b1, 15, 15'h7FFF, 1'b0);
    op(1'b1, 5,  15'h001F, 1'b1);
    op(1'b1, 8,  15'h00AB, 1'b0);
    op(1'b0, 0, '0, 1'b1);
    idle(2);

    // zero-length push still triggers a flush
    op(1'b1, 7, 15'h5555, 1'b0);
    op(1'b1, 0, 15'h7FFF, 1'b1);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      bit p, f;
      p = ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 11) == 0);
      op(p, $urandom_range(0, 15), CODEW'($urandom), f);
    end
    op(1'b0, 0, '0, 1'b1);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
    check("total_bits", obs_bits, exp_bits);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
